life_gen_engine: RTL and testbench
==================================

Name: life_gen_engine

Overview:
Next-generation stage of the clan Game of Life: holds the current generation in a double-buffered GRID_SIZE x GRID_SIZE cell array. On a start pulse it sweeps the grid row-major, one cell per cycle, counts the 8 neighbours and applies the clan life rules. Results go to the shadow buffer, which is swapped in when the sweep ends. A load port seeds the grid; a registered read port feeds display/readout.

Parameters:
GRID_SIZE, 8, cells per row/column (>=2)
GEN_W, 16, width of generation counter
COORD_W, max(1,$clog2(GRID_SIZE)), derived localparam, row/col index width
POP_W, $clog2(GRID_SIZE*GRID_SIZE+1), derived localparam, population count width

Ports:
clk  in  1  sole clock, all logic on posedge
rst  in  1  synchronous active-high reset
cfg_we  in  1  write one cell of the current generation (honoured only when idle)
cfg_row  in  COORD_W  write row
cfg_col  in  COORD_W  write column
cfg_alive  in  1  written alive bit
cfg_clan  in  2  written clan: 0 NEUTRAL, 1 CLAN1, 2 CLAN2, 3 CLAN3
start  in  1  request one generation step (honoured only when idle)
busy  out  1  step in progress
done  out  1  one-cycle pulse when the new generation becomes current
gen_count  out  GEN_W  generations completed since reset
pop_count  out  POP_W  alive cells in the current generation
rd_row  in  COORD_W  read row
rd_col  in  COORD_W  read column
rd_alive  out  1  alive bit of current-generation cell, 1-cycle latency
rd_clan  out  2  clan of current-generation cell, 1-cycle latency

Behaviour:
- Reset: both buffers cleared (alive 0, clan NEUTRAL); buf_sel 0; busy 0, done 0, gen_count 0, pop_count 0, rd_alive 0, rd_clan 0; FSM to IDLE. Reset mid-sweep aborts the step with no partial results kept.
- FSM states: IDLE, RUN, SWAP.
- IDLE: cfg_we with in-range coordinates writes the current buffer at the clock edge. Out-of-range coordinates (>= GRID_SIZE) are ignored. start -> RUN, with cell pointer (0,0) and population accumulator 0.
- cfg_we and start in the same IDLE cycle: the write lands first and the sweep sees it.
- RUN: each cycle, for pointer (r,c):
  - Count alive neighbours at the 8 offsets in the current buffer; off-grid neighbours count as dead (no wrap).
  - Write the result to the shadow buffer at (r,c) and add it to the population accumulator.
  - Advance the pointer row-major. After cell (N-1,N-1) -> SWAP.
  - RUN lasts exactly GRID_SIZE*GRID_SIZE cycles.
- Rules, where n = alive-neighbour count (0..8, 4-bit):
  - Alive cell with n in {2,3} stays alive and keeps its clan; otherwise it dies.
  - Dead cell with n==3 is born. Its clan is the clan held by at least 2 of the 3 live neighbours; if all 3 differ, it is NEUTRAL.
  - Any dead result has clan NEUTRAL.
- SWAP (1 cycle): toggle buf_sel, gen_count += 1 (wraps mod 2^GEN_W), pop_count <= accumulator, done = 1 -> IDLE.
- Timing: with start sampled at edge 0, busy is high from the cycle after that edge through the SWAP cycle inclusive. done is high only in the SWAP cycle. Start-to-done latency is N*N+1 cycles. A new start is accepted in the cycle after done.
- start and cfg_we while busy: ignored entirely, not queued.
- Read port: rd_alive/rd_clan are registered from the current buffer, giving 1-cycle latency. During RUN the port returns the old generation; it returns the new generation from the cycle after SWAP. Out-of-range read -> 0/NEUTRAL.
- pop_count does not track cfg writes; it updates only in SWAP.

Test Plan:
1. Reset, then read all cells -> every rd_alive=0, rd_clan=0. gen_count=0, pop_count=0, busy=0.
2. GRID_SIZE=8: load horizontal blinker (3,2)(3,3)(3,4) as CLAN1, then pulse start -> done exactly 65 cycles later. New generation is vertical (2,3)(3,3)(4,3), all CLAN1; pop_count=3, gen_count=1. A second step restores the horizontal blinker, gen_count=2.
3. Corner boundary: load block (0,0)(0,1)(1,0)(1,1) -> unchanged after 3 steps, pop_count=4, no wrap-induced births at row/col 7.
4. Clan birth: live (2,1)=CLAN2, (2,3)=CLAN2, (1,2)=CLAN3 -> (2,2) born CLAN2. Repeat with clans 1,2,3 -> (2,2) born NEUTRAL.
5. Assert start and cfg_we mid-RUN -> both ignored, done still at cycle 65, grid unchanged by the write. Assert rst at RUN cycle 20 -> all outputs and cells cleared, busy=0, no done pulse.
6. GEN_W=2: run 5 steps on an empty grid -> gen_count sequence 1,2,3,0,1; pop_count stays 0.

Source files
------------

// File: rtl/life_gen_engine_if.sv
// Bus bundle for life_gen_engine: cell load, step control, status and cell readout.
// master = controller/testbench side, slave = engine side.
interface life_gen_engine_if #(
  parameter int GRID_SIZE = 8,
  parameter int GEN_W     = 16
);
  localparam int COORD_W = ($clog2(GRID_SIZE) < 1) ? 1 : $clog2(GRID_SIZE);
  localparam int POP_W   = $clog2(GRID_SIZE * GRID_SIZE + 1);

  logic               cfg_we;
  logic [COORD_W-1:0] cfg_row;
  logic [COORD_W-1:0] cfg_col;
  logic               cfg_alive;
  logic [1:0]         cfg_clan;
  logic               start;
  logic               busy;
  logic               done;
  logic [GEN_W-1:0]   gen_count;
  logic [POP_W-1:0]   pop_count;
  logic [COORD_W-1:0] rd_row;
  logic [COORD_W-1:0] rd_col;
  logic               rd_alive;
  logic [1:0]         rd_clan;

  modport master (
    output cfg_we, cfg_row, cfg_col, cfg_alive, cfg_clan, start, rd_row, rd_col,
    input  busy, done, gen_count, pop_count, rd_alive, rd_clan
  );

  modport slave (
    input  cfg_we, cfg_row, cfg_col, cfg_alive, cfg_clan, start, rd_row, rd_col,
    output busy, done, gen_count, pop_count, rd_alive, rd_clan
  );
endinterface

// File: rtl/life_gen_engine.sv
// Clan Game of Life next-generation engine: double-buffered grid, one cell per cycle
// row-major sweep into the shadow buffer, swapped in when the sweep completes.
module life_gen_engine #(
  parameter int GRID_SIZE = 8,
  parameter int GEN_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  life_gen_engine_if.slave bus
);
  localparam int COORD_W = ($clog2(GRID_SIZE) < 1) ? 1 : $clog2(GRID_SIZE);
  localparam int POP_W   = $clog2(GRID_SIZE * GRID_SIZE + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    SWAP = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic               buf_sel_q, buf_sel_d;
  logic [COORD_W-1:0] row_q, row_d;
  logic [COORD_W-1:0] col_q, col_d;
  logic [POP_W-1:0]   acc_q, acc_d;
  logic [POP_W-1:0]   pop_q, pop_d;
  logic [GEN_W-1:0]   gen_q, gen_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               rd_alive_q, rd_alive_d;
  logic [1:0]         rd_clan_q, rd_clan_d;
  logic               alive_q [2][GRID_SIZE][GRID_SIZE];
  logic               alive_d [2][GRID_SIZE][GRID_SIZE];
  logic [1:0]         clan_q  [2][GRID_SIZE][GRID_SIZE];
  logic [1:0]         clan_d  [2][GRID_SIZE][GRID_SIZE];

  int                 nr_s, nc_s;
  logic               hit_s;
  logic [1:0]         nbr_clan_s;
  logic [3:0]         nbr_cnt_s;
  logic [3:0]         clan_hits_s [4];
  logic [1:0]         born_clan_s;
  logic               cur_alive_s;
  logic [1:0]         cur_clan_s;
  logic               next_alive_s;
  logic [1:0]         next_clan_s;
  logic               cfg_ok_s, rd_ok_s, last_col_s, last_row_s;

  // Neighbour count and per-clan tally of live neighbours around the sweep pointer.
  always_comb begin
    nr_s       = 0;
    nc_s       = 0;
    hit_s      = 1'b0;
    nbr_clan_s = 2'd0;
    nbr_cnt_s  = 4'd0;
    for (int k = 0; k < 4; k++) clan_hits_s[k] = 4'd0;
    for (int dr = -1; dr <= 1; dr++) begin
      for (int dc = -1; dc <= 1; dc++) begin
        nr_s       = int'(row_q) + dr;
        nc_s       = int'(col_q) + dc;
        // Off-grid positions never hit; the wrapped index is only read, never used.
        hit_s      = ((dr != 0) || (dc != 0)) && (nr_s >= 0) && (nr_s < GRID_SIZE) &&
                     (nc_s >= 0) && (nc_s < GRID_SIZE) &&
                     alive_q[buf_sel_q][COORD_W'(nr_s)][COORD_W'(nc_s)];
        nbr_clan_s = clan_q[buf_sel_q][COORD_W'(nr_s)][COORD_W'(nc_s)];
        nbr_cnt_s  = nbr_cnt_s + (hit_s ? 4'd1 : 4'd0);
        for (int k = 0; k < 4; k++)
          clan_hits_s[k] = clan_hits_s[k] + ((hit_s && (nbr_clan_s == 2'(k))) ? 4'd1 : 4'd0);
      end
    end
    // With exactly three live neighbours at most one clan can reach two hits.
    born_clan_s = 2'd0;
    for (int k = 0; k < 4; k++)
      born_clan_s = (clan_hits_s[k] >= 4'd2) ? 2'(k) : born_clan_s;
    cur_alive_s  = alive_q[buf_sel_q][row_q][col_q];
    cur_clan_s   = clan_q[buf_sel_q][row_q][col_q];
    next_alive_s = cur_alive_s ? ((nbr_cnt_s == 4'd2) || (nbr_cnt_s == 4'd3))
                               : (nbr_cnt_s == 4'd3);
    next_clan_s  = !next_alive_s ? 2'd0 : (cur_alive_s ? cur_clan_s : born_clan_s);
  end

  // Next-state, buffer update and registered-output logic.
  always_comb begin
    state_d    = state_q;
    buf_sel_d  = buf_sel_q;
    row_d      = row_q;
    col_d      = col_q;
    acc_d      = acc_q;
    pop_d      = pop_q;
    gen_d      = gen_q;
    alive_d    = alive_q;
    clan_d     = clan_q;
    cfg_ok_s   = ({1'b0, bus.cfg_row} < (COORD_W + 1)'(GRID_SIZE)) &&
                 ({1'b0, bus.cfg_col} < (COORD_W + 1)'(GRID_SIZE));
    rd_ok_s    = ({1'b0, bus.rd_row} < (COORD_W + 1)'(GRID_SIZE)) &&
                 ({1'b0, bus.rd_col} < (COORD_W + 1)'(GRID_SIZE));
    last_col_s = (col_q == COORD_W'(GRID_SIZE - 1));
    last_row_s = (row_q == COORD_W'(GRID_SIZE - 1));
    case (state_q)
      IDLE: begin
        alive_d[buf_sel_q][bus.cfg_row][bus.cfg_col] = (bus.cfg_we && cfg_ok_s) ?
            bus.cfg_alive : alive_q[buf_sel_q][bus.cfg_row][bus.cfg_col];
        clan_d[buf_sel_q][bus.cfg_row][bus.cfg_col]  = (bus.cfg_we && cfg_ok_s) ?
            bus.cfg_clan : clan_q[buf_sel_q][bus.cfg_row][bus.cfg_col];
        row_d   = {COORD_W{1'b0}};
        col_d   = {COORD_W{1'b0}};
        acc_d   = {POP_W{1'b0}};
        state_d = bus.start ? RUN : IDLE;
      end
      RUN: begin
        alive_d[~buf_sel_q][row_q][col_q] = next_alive_s;
        clan_d[~buf_sel_q][row_q][col_q]  = next_clan_s;
        acc_d = acc_q + POP_W'(next_alive_s);
        if (last_col_s) begin
          col_d   = {COORD_W{1'b0}};
          row_d   = last_row_s ? {COORD_W{1'b0}} : (row_q + COORD_W'(1));
          state_d = last_row_s ? SWAP : RUN;
        end else begin
          col_d   = col_q + COORD_W'(1);
        end
      end
      SWAP: begin
        buf_sel_d = ~buf_sel_q;
        gen_d     = gen_q + GEN_W'(1);
        pop_d     = acc_q;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
    busy_d     = (state_d != IDLE);
    done_d     = (state_d == SWAP);
    rd_alive_d = rd_ok_s ? alive_q[buf_sel_q][bus.rd_row][bus.rd_col] : 1'b0;
    rd_clan_d  = rd_ok_s ? clan_q[buf_sel_q][bus.rd_row][bus.rd_col] : 2'd0;
  end

  // State, grid buffers and outputs; synchronous reset discards any sweep in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      buf_sel_q  <= 1'b0;
      row_q      <= {COORD_W{1'b0}};
      col_q      <= {COORD_W{1'b0}};
      acc_q      <= {POP_W{1'b0}};
      pop_q      <= {POP_W{1'b0}};
      gen_q      <= {GEN_W{1'b0}};
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      rd_alive_q <= 1'b0;
      rd_clan_q  <= 2'd0;
      for (int b = 0; b < 2; b++)
        for (int r = 0; r < GRID_SIZE; r++)
          for (int c = 0; c < GRID_SIZE; c++) begin
            alive_q[b][r][c] <= 1'b0;
            clan_q[b][r][c]  <= 2'd0;
          end
    end else begin
      state_q    <= state_d;
      buf_sel_q  <= buf_sel_d;
      row_q      <= row_d;
      col_q      <= col_d;
      acc_q      <= acc_d;
      pop_q      <= pop_d;
      gen_q      <= gen_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      rd_alive_q <= rd_alive_d;
      rd_clan_q  <= rd_clan_d;
      alive_q    <= alive_d;
      clan_q     <= clan_d;
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.gen_count = gen_q;
  assign bus.pop_count = pop_q;
  assign bus.rd_alive  = rd_alive_q;
  assign bus.rd_clan   = rd_clan_q;
endmodule

// File: tb/tb_life_gen_engine.sv
// Self-checking bench for life_gen_engine: reference grid model, scoreboard-checked
// readback, table-driven cell checks and hand-written sequences for timing corners.
module tb_life_gen_engine;
  localparam int N  = 8;
  localparam int CW = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  life_gen_engine_if #(.GRID_SIZE(N), .GEN_W(16)) bus ();
  life_gen_engine_if #(.GRID_SIZE(N), .GEN_W(2))  bus2 ();

  life_gen_engine #(.GRID_SIZE(N), .GEN_W(16)) dut  (.clk(clk), .rst(rst), .bus(bus));
  life_gen_engine #(.GRID_SIZE(N), .GEN_W(2))  dut2 (.clk(clk), .rst(rst), .bus(bus2));

  typedef struct {
    int         r;
    int         c;
    logic [2:0] exp;   // {alive, clan}
  } vec_t;

  int         n_cmp = 0;
  int         n_bad = 0;
  bit         m_alive [N][N];
  logic [1:0] m_clan  [N][N];
  int         m_gen, m_pop;
  vec_t       sb_q [$];
  vec_t       vecs [6];

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic model_clear();
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) begin
        m_alive[r][c] = 1'b0;
        m_clan[r][c]  = 2'd0;
      end
    m_gen = 0;
    m_pop = 0;
  endtask

  // Reference next generation: explicit neighbour list, pairwise clan majority.
  task automatic model_step();
    int drs [8] = '{-1, -1, -1, 0, 0, 1, 1, 1};
    int dcs [8] = '{-1, 0, 1, -1, 1, -1, 0, 1};
    bit         na [N][N];
    logic [1:0] nc [N][N];
    m_pop = 0;
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) begin
        int n = 0;
        logic [1:0] cl [3];
        cl[0] = 2'd0; cl[1] = 2'd0; cl[2] = 2'd0;
        for (int k = 0; k < 8; k++) begin
          int rr = r + drs[k];
          int cc = c + dcs[k];
          if (rr >= 0 && rr < N && cc >= 0 && cc < N && m_alive[rr][cc]) begin
            if (n < 3) cl[n] = m_clan[rr][cc];
            n++;
          end
        end
        if (m_alive[r][c]) begin
          na[r][c] = (n == 2 || n == 3);
          nc[r][c] = na[r][c] ? m_clan[r][c] : 2'd0;
        end else if (n == 3) begin
          na[r][c] = 1'b1;
          nc[r][c] = (cl[0] == cl[1] || cl[0] == cl[2]) ? cl[0] :
                     (cl[1] == cl[2]) ? cl[1] : 2'd0;
        end else begin
          na[r][c] = 1'b0;
          nc[r][c] = 2'd0;
        end
      end
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) begin
        m_alive[r][c] = na[r][c];
        m_clan[r][c]  = nc[r][c];
        if (na[r][c]) m_pop++;
      end
    m_gen++;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_clear();
  endtask

  task automatic write_cell(input int r, input int c, input bit a, input logic [1:0] cl);
    @(negedge clk);
    bus.cfg_we    = 1'b1;
    bus.cfg_row   = CW'(r);
    bus.cfg_col   = CW'(c);
    bus.cfg_alive = a;
    bus.cfg_clan  = cl;
    @(negedge clk);
    bus.cfg_we    = 1'b0;
    m_alive[r][c] = a;
    m_clan[r][c]  = cl;
  endtask

  // Drive a read address, queue the expectation, compare one edge later.
  task automatic read_check(input string name, input vec_t v);
    vec_t e;
    bus.rd_row = CW'(v.r);
    bus.rd_col = CW'(v.c);
    sb_q.push_back(v);
    @(negedge clk);
    e = sb_q.pop_front();
    check($sformatf("%s[%0d,%0d]", name, e.r, e.c), int'({bus.rd_alive, bus.rd_clan}), int'(e.exp));
  endtask

  task automatic check_grid(input string name);
    vec_t v;
    for (int i = 0; i < N * N; i++) begin
      v.r   = i / N;
      v.c   = i % N;
      v.exp = {m_alive[v.r][v.c], m_clan[v.r][v.c]};
      read_check(name, v);
    end
  endtask

  // One generation step; optionally inject start+cfg_we mid-sweep at cycle inject_at.
  task automatic step(input string name, input int inject_at);
    int cnt = 0;
    bit seen = 1'b0;
    @(negedge clk);
    bus.start = 1'b1;
    while (!seen && cnt < 200) begin
      @(negedge clk);
      cnt++;
      bus.start  = 1'b0;
      bus.cfg_we = 1'b0;
      if (cnt == 1) check({name, "_busy"}, int'(bus.busy), 1);
      seen = bus.done;
      if (cnt == inject_at) begin
        bus.start     = 1'b1;
        bus.cfg_we    = 1'b1;
        bus.cfg_row   = CW'(7);
        bus.cfg_col   = CW'(7);
        bus.cfg_alive = 1'b1;
        bus.cfg_clan  = 2'd3;
      end
    end
    check({name, "_latency"}, cnt, N * N + 1);
    model_step();
    @(negedge clk);
    check({name, "_gen"}, int'(bus.gen_count), m_gen);
    check({name, "_pop"}, int'(bus.pop_count), m_pop);
    check({name, "_idle"}, int'({bus.busy, bus.done}), 0);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t v;
    int   cnt;
    bit   seen;
    int   gen2_exp [5] = '{1, 2, 3, 0, 1};

    rst = 1'b1;
    bus.cfg_we = 1'b0; bus.cfg_row = '0; bus.cfg_col = '0; bus.cfg_alive = 1'b0;
    bus.cfg_clan = 2'd0; bus.start = 1'b0; bus.rd_row = '0; bus.rd_col = '0;
    bus2.cfg_we = 1'b0; bus2.cfg_row = '0; bus2.cfg_col = '0; bus2.cfg_alive = 1'b0;
    bus2.cfg_clan = 2'd0; bus2.start = 1'b0; bus2.rd_row = '0; bus2.rd_col = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    model_clear();

    // Reset state
    check("rst_busy", int'(bus.busy), 0);
    check("rst_done", int'(bus.done), 0);
    check("rst_gen", int'(bus.gen_count), 0);
    check("rst_pop", int'(bus.pop_count), 0);
    check_grid("rst_grid");

    // Blinker oscillation
    vecs[0] = '{2, 3, 3'b101};
    vecs[1] = '{3, 3, 3'b101};
    vecs[2] = '{4, 3, 3'b101};
    vecs[3] = '{3, 2, 3'b000};
    vecs[4] = '{3, 4, 3'b000};
    vecs[5] = '{7, 7, 3'b000};
    write_cell(3, 2, 1'b1, 2'd1);
    write_cell(3, 3, 1'b1, 2'd1);
    write_cell(3, 4, 1'b1, 2'd1);
    step("blink1", 0);
    check("blink1_pop3", int'(bus.pop_count), 3);
    check("blink1_gen1", int'(bus.gen_count), 1);
    for (int i = 0; i < 6; i++) read_check("blink1_vec", vecs[i]);
    check_grid("blink1_grid");
    step("blink2", 0);
    check("blink2_gen2", int'(bus.gen_count), 2);
    v = '{3, 2, 3'b101};
    read_check("blink2_back", v);
    check_grid("blink2_grid");

    // Corner block is a still life; no wrap-around births
    do_reset();
    write_cell(0, 0, 1'b1, 2'd2);
    write_cell(0, 1, 1'b1, 2'd2);
    write_cell(1, 0, 1'b1, 2'd2);
    write_cell(1, 1, 1'b1, 2'd2);
    for (int s = 0; s < 3; s++) begin
      step("block", 0);
      check("block_pop4", int'(bus.pop_count), 4);
      check_grid("block_grid");
    end

    // Clan majority birth, then three-way tie births NEUTRAL
    do_reset();
    write_cell(2, 1, 1'b1, 2'd2);
    write_cell(2, 3, 1'b1, 2'd2);
    write_cell(1, 2, 1'b1, 2'd3);
    step("clan_maj", 0);
    v = '{2, 2, 3'b110};
    read_check("clan_maj_birth", v);
    check_grid("clan_maj_grid");
    do_reset();
    write_cell(2, 1, 1'b1, 2'd1);
    write_cell(2, 3, 1'b1, 2'd2);
    write_cell(1, 2, 1'b1, 2'd3);
    step("clan_tie", 0);
    v = '{2, 2, 3'b100};
    read_check("clan_tie_birth", v);
    check_grid("clan_tie_grid");

    // start and cfg_we mid-RUN are ignored
    step("inject", 10);
    check_grid("inject_grid");

    // Reset 20 cycles into a sweep aborts it and clears everything
    write_cell(4, 4, 1'b1, 2'd1);
    write_cell(4, 5, 1'b1, 2'd1);
    write_cell(4, 6, 1'b1, 2'd1);
    @(negedge clk);
    bus.start = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      bus.start = 1'b0;
      seen = seen | bus.done;
    end
    rst = 1'b1;
    @(negedge clk);
    check("abort_busy", int'(bus.busy), 0);
    @(negedge clk);
    rst = 1'b0;
    model_clear();
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      seen = seen | bus.done;
    end
    check("abort_no_done", int'(seen), 0);
    check("abort_gen", int'(bus.gen_count), 0);
    check("abort_pop", int'(bus.pop_count), 0);
    check("abort_busy_after", int'(bus.busy), 0);
    check_grid("abort_grid");

    // Narrow generation counter wraps
    for (int s = 0; s < 5; s++) begin
      @(negedge clk);
      bus2.start = 1'b1;
      cnt = 0;
      seen = 1'b0;
      while (!seen && cnt < 200) begin
        @(negedge clk);
        cnt++;
        bus2.start = 1'b0;
        seen = bus2.done;
      end
      check("gen2_latency", cnt, N * N + 1);
      @(negedge clk);
      check($sformatf("gen2_count_%0d", s), int'(bus2.gen_count), gen2_exp[s]);
      check("gen2_pop", int'(bus2.pop_count), 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
